// File: rtl/step_seq_pkg.sv
// Shared definitions for the step sequencer controller: state encoding,
// ring geometry and the shadow-phase increment helper.
package step_seq_pkg;

  localparam int PHASES_DEF = 5;
  localparam int PHASE_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STEP   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Advance a ring position by one, wrapping after the last phase.
  function automatic logic [PHASE_W-1:0] phase_inc(
    input logic [PHASE_W-1:0] cur,
    input logic [PHASE_W-1:0] last
  );
    logic [PHASE_W-1:0] nxt;
    if (cur == last) begin
      nxt = 3'd0;
    end else begin
      nxt = cur + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/step_interval_div.sv
// Loadable down-counter that paces the gap between sequencer strobes;
// decrements saturate at zero and the zero flag drives the WAIT exit.
module step_interval_div #(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             dec,
  output logic [DIV_W-1:0] count,
  output logic             zero
);

  logic [DIV_W-1:0] count_r;

  // Counter register: load wins over decrement; decrement only while non-zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {DIV_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {DIV_W{1'b0}})) begin
      count_r <= count_r - {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {DIV_W{1'b0}});

endmodule

// File: rtl/step_seq_ctrl.sv
// Command-driven strobe generator for the 5-phase ring sequencer: turns
// "advance N phases every cmd_div+2 cycles" into enable+advance pulses.
module step_seq_ctrl
  import step_seq_pkg::*;
#(
  parameter int PHASES = PHASES_DEF,
  parameter int CNT_W  = 8,
  parameter int DIV_W  = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [CNT_W-1:0]   cmd_steps,
  input  logic [DIV_W-1:0]   cmd_div,
  input  logic               abort,
  output logic               seq_enable,
  output logic               seq_a,
  output logic [PHASE_W-1:0] phase,
  output logic [CNT_W-1:0]   steps_left,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASES - 1);
  localparam logic [CNT_W-1:0]   STEPS_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_r;
  state_e             state_s;
  logic [CNT_W-1:0]   steps_r;
  logic [DIV_W-1:0]   cmd_div_r;
  logic [PHASE_W-1:0] phase_r;
  logic               cmd_ready_r;
  logic               seq_strobe_r;
  logic               busy_r;
  logic               done_r;
  logic               aborted_r;

  logic               accept_s;
  logic               abort_end_s;
  logic               div_load_s;
  logic [DIV_W-1:0]   div_load_val_s;
  logic               div_dec_s;
  logic [DIV_W-1:0]   div_count_s;
  logic               div_zero_s;

  step_interval_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (div_load_s),
    .load_val (div_load_val_s),
    .dec      (div_dec_s),
    .count    (div_count_s),
    .zero     (div_zero_s)
  );

  // Next-state and divider control; abort takes priority over timing in WAIT/STEP.
  always_comb begin
    state_s        = state_r;
    accept_s       = 1'b0;
    abort_end_s    = 1'b0;
    div_load_s     = 1'b0;
    div_load_val_s = cmd_div_r;
    div_dec_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept_s       = 1'b1;
          div_load_s     = 1'b1;
          div_load_val_s = cmd_div;
          if (cmd_steps == {CNT_W{1'b0}}) begin
            state_s = ST_FINISH;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          abort_end_s = 1'b1;
          state_s     = ST_FINISH;
        end else if (div_zero_s) begin
          state_s = ST_STEP;
        end else begin
          div_dec_s = 1'b1;
          state_s   = ST_WAIT;
        end
      end
      ST_STEP: begin
        // The strobe in this cycle counts even when abort arrives with it.
        if (abort) begin
          abort_end_s = 1'b1;
          state_s     = ST_FINISH;
        end else if (steps_r == STEPS_ONE) begin
          state_s = ST_FINISH;
        end else begin
          div_load_s = 1'b1;
          state_s    = ST_WAIT;
        end
      end
      ST_FINISH: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Command latch, step counter and shadow phase.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      steps_r   <= {CNT_W{1'b0}};
      cmd_div_r <= {DIV_W{1'b0}};
      phase_r   <= {PHASE_W{1'b0}};
    end else if (accept_s) begin
      steps_r   <= cmd_steps;
      cmd_div_r <= cmd_div;
      phase_r   <= phase_r;
    end else if ((state_r == ST_STEP) && (steps_r != {CNT_W{1'b0}})) begin
      steps_r   <= steps_r - STEPS_ONE;
      cmd_div_r <= cmd_div_r;
      phase_r   <= phase_inc(phase_r, PHASE_LAST);
    end else begin
      steps_r   <= steps_r;
      cmd_div_r <= cmd_div_r;
      phase_r   <= phase_r;
    end
  end

  // Outputs are registered from the next state so they line up with state_r.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready_r  <= 1'b1;
      seq_strobe_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      aborted_r    <= 1'b0;
    end else begin
      cmd_ready_r  <= (state_s == ST_IDLE);
      seq_strobe_r <= (state_s == ST_STEP);
      busy_r       <= (state_s != ST_IDLE);
      done_r       <= (state_s == ST_FINISH);
      aborted_r    <= abort_end_s;
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign seq_enable = seq_strobe_r;
  assign seq_a      = seq_strobe_r;
  assign phase      = phase_r;
  assign steps_left = steps_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign aborted    = aborted_r;

endmodule
